cf_angle_packetizer: RTL
========================

Name: cf_angle_packetizer

Overview:
- Consumer end of the complementary-filter output interface.
- Collects the three per-axis fused angles (x_final/y_final/z_final). Each axis arrives with its own valid strobe, and the strobes may be skewed.
- Aligns the three axes into one sample set, then serialises the set as a 10-byte framed packet on a valid/ready byte stream toward the host link (UART/SPI bridge).

Parameters:
- SYNC0, 8'hA5, first sync byte
- SYNC1, 8'h5A, second sync byte
- TIMEOUT, 64, max cycles a partial set may wait for its remaining axes
- DROP_W, 8, width of the saturating drop counter

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- x_final  input  16  signed X angle from filter
- y_final  input  16  signed Y angle from filter
- z_final  input  16  signed Z angle from filter
- valid_x  input  1  x_final valid strobe (one cycle)
- valid_y  input  1  y_final valid strobe
- valid_z  input  1  z_final valid strobe
- tx_data  output  8  packet byte
- tx_valid  output  1  tx_data valid
- tx_ready  input  1  sink accepts byte when high with tx_valid
- busy  output  1  frame in transmission
- overrun  output  1  sticky: axis overwritten before set completed
- drop_cnt  output  DROP_W  saturating count of discarded samples/sets

Behaviour:
- Reset: the interface is one clock (clk) with a synchronous active-high reset (rst). All state clears on the rising edge with rst=1:
  - tx_data=0, tx_valid=0, busy=0, overrun=0, drop_cnt=0
  - seq=0, capture flags=0, FSM=IDLE
  - Reset mid-frame abandons the frame; tx_valid is 0 the cycle after reset.
- Capture stage, per axis:
  - On valid_a, the axis value is registered and flag_a is set.
  - If flag_a is already set: value is overwritten, overrun is set, and drop_cnt increments (saturates at 2^DROP_W-1).
- Set complete: all three flags set (pending).
- Timeout:
  - A counter runs while 0 < flags < all three.
  - After TIMEOUT cycles: all flags clear, drop_cnt+1, no frame is sent.
  - The counter resets whenever the set completes or the flags clear.
- FSM states: IDLE, SEND.
  - IDLE with pending:
    - The three values are copied to a shadow frame buffer and all flags clear.
    - A valid arriving that same cycle sets its flag with the new value (the new set wins over the clear).
    - Go to SEND.
  - SEND, byte order: index 0..9 = SYNC0, SYNC1, seq, X[15:8], X[7:0], Y[15:8], Y[7:0], Z[15:8], Z[7:0], CHK.
    - CHK = sum of bytes 2..8, modulo 256.
  - Latency: pending in IDLE at cycle N gives tx_valid=1 with SYNC0 at cycle N+1.
- Handshake:
  - A byte advances only on tx_valid & tx_ready.
  - tx_data and tx_valid are held stable while tx_ready=0.
  - tx_valid never drops mid-frame except on reset.
- End of frame:
  - On accepting byte 9: seq increments (wraps 255→0).
  - If pending, the next frame starts with SYNC0 the following cycle (back-to-back); otherwise tx_valid=0, busy=0, return to IDLE.
- During SEND, capture keeps accepting a new set. The shadow buffer is never modified mid-frame.
- busy = 1 exactly while FSM = SEND.
- Values are raw two's-complement bytes. No sign extension or scaling.

Decomposition:
- Package cf_pkt_pkg:
  - FRAME_LEN=10
  - default sync constants
  - FSM state typedef (IDLE, SEND)
  - byte-index typedef (4 bits)
- Sub-module cf_axis_capture: value register, flag, overwrite detect. Instantiated three times.
- Timeout, FSM, checksum and serialiser live in the top block.

Test Plan:
- Reset, then valid_x/y/z in the same cycle with X=16'h1234, Y=16'hFEDC, Z=16'h0001, tx_ready=1 → bytes A5 5A 00 12 34 FE DC 00 01 21 on consecutive cycles starting one cycle after capture; next frame seq=01.
- Skewed strobes: valid_x at t, valid_y at t+3, valid_z at t+5 → SYNC0 at t+7, payload equals the captured values, drop_cnt=0.
- Backpressure: tx_ready toggles 1,0,0,1,... → tx_data constant during stalls, exactly 10 accepted bytes, correct CHK; a second full set arriving mid-frame is sent back-to-back with seq+1.
- Overwrite: valid_x with 16'h0100 then 16'h0200, then valid_y and valid_z → frame carries X=02 00; overrun=1, drop_cnt=1.
- Timeout: only valid_x, then idle 64 cycles → flags cleared, drop_cnt=1, tx_valid stays 0; a subsequent full set produces a normal frame.
- Reset mid-frame: rst asserted one cycle after byte 4 (X[7:0]) is accepted → tx_valid=0, busy=0, seq=0 next cycle; the following set's frame starts A5 5A 00.

Source files
------------

// File: rtl/cf_pkt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cf_pkt_pkg
//  Description : Shared constants, types and the frame checksum helper for
//                the complementary-filter angle packetizer.
//  Revision    : 1.0 - initial release
// ============================================================================
package cf_pkt_pkg;

    // Number of bytes in one framed packet: 2 sync, seq, 6 payload, checksum
    localparam int FRAME_LEN = 10;

    // Default sync pattern that opens every frame
    localparam logic [7:0] c_sync0_default = 8'hA5;
    localparam logic [7:0] c_sync1_default = 8'h5A;

    // Serialiser state encoding
    typedef logic [0:0] cf_state_t;
    localparam cf_state_t c_st_idle = 1'b0;
    localparam cf_state_t c_st_send = 1'b1;

    // Byte position within a frame (0..FRAME_LEN-1)
    typedef logic [3:0] cf_idx_t;
    localparam cf_idx_t c_last_idx = 4'd9;

    // Checksum covers the sequence byte and the six payload bytes, mod 256
    function automatic logic [7:0] cf_checksum(
        input logic [7:0]  seq,
        input logic [15:0] x,
        input logic [15:0] y,
        input logic [15:0] z
    );
        cf_checksum = seq + x[15:8] + x[7:0] + y[15:8] + y[7:0]
                    + z[15:8] + z[7:0];
    endfunction

endpackage : cf_pkt_pkg
`default_nettype wire

// File: rtl/cf_axis_capture.sv
`default_nettype none
// ============================================================================
//  Module      : cf_axis_capture
//  Description : Single-axis capture register. Holds the latest angle sample,
//                flags it as present, and reports when a still-unconsumed
//                sample is overwritten by a newer one.
//  Revision    : 1.0 - initial release
// ============================================================================
module cf_axis_capture #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_clear,
    output logic [DATA_W-1:0] o_value,
    output logic              o_flag,
    output logic              o_overwrite
);

    logic [DATA_W-1:0] r_value;
    logic              r_flag;

    // A fresh sample always wins over a clear in the same cycle, so a new set
    // can start while the previous one is being consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_value <= '0;
            r_flag  <= 1'b0;
        end else if (i_valid) begin
            r_value <= i_data;
            r_flag  <= 1'b1;
        end else if (i_clear) begin
            r_flag  <= 1'b0;
        end
    end

    // Overwrite only counts when the old sample was not consumed this cycle
    assign o_overwrite = i_valid & r_flag & ~i_clear;
    assign o_value     = r_value;
    assign o_flag      = r_flag;

endmodule : cf_axis_capture
`default_nettype wire

// File: rtl/cf_angle_packetizer.sv
`default_nettype none
// ============================================================================
//  Module      : cf_angle_packetizer
//  Description : Aligns skewed X/Y/Z fused-angle strobes into one sample set
//                and serialises each set as a 10-byte framed packet on a
//                valid/ready byte stream:
//                SYNC0 SYNC1 seq Xh Xl Yh Yl Zh Zl CHK
//  Revision    : 1.0 - initial release
// ============================================================================
module cf_angle_packetizer
    import cf_pkt_pkg::*;
#(
    parameter logic [7:0] SYNC0   = c_sync0_default,
    parameter logic [7:0] SYNC1   = c_sync1_default,
    parameter int         TIMEOUT = 64,
    parameter int         DROP_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       x_final,
    input  logic [15:0]       y_final,
    input  logic [15:0]       z_final,
    input  logic              valid_x,
    input  logic              valid_y,
    input  logic              valid_z,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              overrun,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam int c_to_w = $clog2(TIMEOUT + 1);
    localparam logic [c_to_w-1:0]  c_to_last  = c_to_w'(TIMEOUT - 1);
    localparam logic [DROP_W+2:0]  c_drop_max = {3'b000, {DROP_W{1'b1}}};

    // ------------------------------------------------------------------
    // Per-axis capture
    // ------------------------------------------------------------------
    logic        w_valid [3];
    logic [15:0] w_data  [3];
    logic [15:0] w_value [3];
    logic [2:0]  w_flag;
    logic [2:0]  w_ovw;
    logic        w_clear;

    assign w_valid[0] = valid_x;
    assign w_valid[1] = valid_y;
    assign w_valid[2] = valid_z;
    assign w_data[0]  = x_final;
    assign w_data[1]  = y_final;
    assign w_data[2]  = z_final;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_axis
            cf_axis_capture #(
                .DATA_W (16)
            ) u_cap (
                .clk         (clk),
                .rst         (rst),
                .i_valid     (w_valid[g]),
                .i_data      (w_data[g]),
                .i_clear     (w_clear),
                .o_value     (w_value[g]),
                .o_flag      (w_flag[g]),
                .o_overwrite (w_ovw[g])
            );
        end
    endgenerate

    logic w_pending;
    logic w_partial;

    assign w_pending = &w_flag;
    assign w_partial = (|w_flag) & ~(&w_flag);

    // ------------------------------------------------------------------
    // Partial-set timeout
    // ------------------------------------------------------------------
    logic [c_to_w-1:0] r_to_cnt;
    logic              w_timeout;

    // Fires on the TIMEOUT-th consecutive cycle with an incomplete set
    assign w_timeout = w_partial && (r_to_cnt == c_to_last);

    // Count cycles spent with an incomplete set; restart once it resolves
    always_ff @(posedge clk) begin
        if (rst || !w_partial || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Serialiser FSM
    // ------------------------------------------------------------------
    cf_state_t   r_state;
    cf_idx_t     r_idx;
    cf_idx_t     w_next_idx;
    logic [7:0]  r_tx_data;
    logic [7:0]  r_seq;
    logic [15:0] r_sx;
    logic [15:0] r_sy;
    logic [15:0] r_sz;
    logic [7:0]  w_next_byte;
    logic [7:0]  w_chk;
    logic        w_accept;
    logic        w_last;
    logic        w_take;

    assign w_accept   = (r_state == c_st_send) & tx_ready;
    assign w_last     = (r_idx == c_last_idx);
    assign w_next_idx = r_idx + 4'd1;
    assign w_chk      = cf_checksum(r_seq, r_sx, r_sy, r_sz);

    // A set is consumed either from IDLE or right at the end of a frame
    assign w_take  = ((r_state == c_st_idle) && w_pending) ||
                     (w_accept && w_last && w_pending);
    assign w_clear = w_take | w_timeout;

    // Byte to present after the current one is accepted
    always_comb begin
        w_next_byte = 8'h00;
        case (w_next_idx)
            4'd0:    w_next_byte = SYNC0;
            4'd1:    w_next_byte = SYNC1;
            4'd2:    w_next_byte = r_seq;
            4'd3:    w_next_byte = r_sx[15:8];
            4'd4:    w_next_byte = r_sx[7:0];
            4'd5:    w_next_byte = r_sy[15:8];
            4'd6:    w_next_byte = r_sy[7:0];
            4'd7:    w_next_byte = r_sz[15:8];
            4'd8:    w_next_byte = r_sz[7:0];
            4'd9:    w_next_byte = w_chk;
            default: w_next_byte = 8'h00;
        endcase
    end

    // Frame sequencing: snapshot the set, walk the byte index on each
    // accepted byte, and chain frames back-to-back when a set is waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_idx     <= '0;
            r_tx_data <= 8'h00;
            r_seq     <= 8'h00;
            r_sx      <= 16'h0000;
            r_sy      <= 16'h0000;
            r_sz      <= 16'h0000;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_pending) begin
                        r_sx      <= w_value[0];
                        r_sy      <= w_value[1];
                        r_sz      <= w_value[2];
                        r_idx     <= '0;
                        r_tx_data <= SYNC0;
                        r_state   <= c_st_send;
                    end
                end
                c_st_send: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_seq <= r_seq + 8'd1;
                            r_idx <= '0;
                            if (w_pending) begin
                                r_sx      <= w_value[0];
                                r_sy      <= w_value[1];
                                r_sz      <= w_value[2];
                                r_tx_data <= SYNC0;
                            end else begin
                                r_state <= c_st_idle;
                            end
                        end else begin
                            r_idx     <= w_next_idx;
                            r_tx_data <= w_next_byte;
                        end
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Error reporting
    // ------------------------------------------------------------------
    logic [2:0]        w_drop_inc;
    logic [DROP_W+2:0] w_drop_sum;
    logic [DROP_W-1:0] r_drop_cnt;
    logic              r_overrun;

    assign w_drop_inc = {2'b00, w_ovw[0]} + {2'b00, w_ovw[1]}
                      + {2'b00, w_ovw[2]} + {2'b00, w_timeout};
    assign w_drop_sum = {3'b000, r_drop_cnt} + {{DROP_W{1'b0}}, w_drop_inc};

    // Saturating count of overwritten samples and timed-out sets
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop_sum > c_drop_max) begin
            r_drop_cnt <= c_drop_max[DROP_W-1:0];
        end else begin
            r_drop_cnt <= w_drop_sum[DROP_W-1:0];
        end
    end

    // Sticky flag: some axis sample was lost to an overwrite
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (|w_ovw) begin
            r_overrun <= 1'b1;
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_valid = (r_state == c_st_send);
    assign busy     = (r_state == c_st_send);
    assign overrun  = r_overrun;
    assign drop_cnt = r_drop_cnt;

endmodule : cf_angle_packetizer
`default_nettype wire
